// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: PDM microphone capture controller.
//   Generates mic_clk from clk, discards WARMUP_EDGES mic_clk rising edges after
//   enable, then integrates mic_data over NUM_PHASES staggered windows of WIN_LEN
//   edges each and pushes every completed window's ones-count into a
//   first-word-fall-through FIFO.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              capture request (low returns to IDLE next cycle)
//   mic_clk, mic_lr_sel microphone clock and channel select (always 0)
//   mic_data            PDM bit, sampled one clk after each mic_clk rise
//   s_valid/s_data/s_ready  FWFT sample stream
//   overflow, overflow_clr  sticky drop flag and its clear
//   busy                high outside IDLE
// Configuration: define PDM_CAPTURE_SIGNED_EN to emit (count - WIN_LEN/2) as a
// saturated two's complement value instead of the raw unsigned count.
module pdm_capture_ctrl #(
  parameter int unsigned CLK_DIV      = 20,
  parameter int unsigned WIN_LEN      = 128,
  parameter int unsigned NUM_PHASES   = 4,
  parameter int unsigned WARMUP_EDGES = 1024,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       mic_clk,
  output logic       mic_lr_sel,
  input  logic       mic_data,
  output logic       s_valid,
  output logic [7:0] s_data,
  input  logic       s_ready,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic       busy
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned WARM_W = (WARMUP_EDGES > 1) ? $clog2(WARMUP_EDGES) : 1;
  localparam int unsigned STRIDE = WIN_LEN / NUM_PHASES;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_EDGES - 1);
  localparam logic [7:0]        EDGE_LAST = 8'(WIN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic                strobe;
  logic [WARM_W-1:0]   warm_cnt;
  logic [7:0]          edge_cnt;
  logic [7:0]          acc [NUM_PHASES];
  logic [NUM_PHASES-1:0] primed;  // phase has restarted since entering RUN

  logic       push;
  logic [7:0] push_cnt;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic b);
    return (a == 8'hff) ? a : a + {7'd0, b};
  endfunction

  function automatic logic [7:0] phase_start(input int unsigned p);
    return 8'(p * STRIDE);
  endfunction

  // A window closes on the strobe just before its phase restarts.
  function automatic logic [7:0] phase_last(input int unsigned p);
    return (p == 0) ? EDGE_LAST : 8'(p * STRIDE - 1);
  endfunction

  function automatic logic [7:0] encode(input logic [7:0] cnt);
`ifdef PDM_CAPTURE_SIGNED_EN
    logic signed [9:0] half;
    logic signed [9:0] v;
    half = 10'(WIN_LEN / 2);
    v    = $signed({2'b00, cnt}) - half;
    if (v > 10'sd127) begin
      return 8'h7f;
    end else if (v < -10'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
`else
    return cnt;
`endif
  endfunction

  assign mic_lr_sel = 1'b0;
  assign busy       = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      div_cnt  <= '0;
      mic_clk  <= 1'b0;
      strobe   <= 1'b0;
      warm_cnt <= '0;
      edge_cnt <= '0;
      primed   <= '0;
      for (int p = 0; p < NUM_PHASES; p++) acc[p] <= '0;
    end else if (!enable) begin
      // Dropping enable abandons any open windows; the FIFO is untouched.
      state    <= StIdle;
      div_cnt  <= '0;
      mic_clk  <= 1'b0;
      strobe   <= 1'b0;
      warm_cnt <= '0;
      edge_cnt <= '0;
      primed   <= '0;
      for (int p = 0; p < NUM_PHASES; p++) acc[p] <= '0;
    end else if (state == StIdle) begin
      state <= StWarmup;
    end else begin
      strobe <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        mic_clk <= ~mic_clk;
        strobe  <= ~mic_clk;  // registered, so it lands the cycle after the rise
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (strobe) begin
        if (state == StWarmup) begin
          if (warm_cnt == WARM_LAST) begin
            state <= StRun;
          end else begin
            warm_cnt <= warm_cnt + WARM_W'(1);
          end
        end else begin
          edge_cnt <= (edge_cnt == EDGE_LAST) ? 8'd0 : edge_cnt + 8'd1;
          for (int p = 0; p < NUM_PHASES; p++) begin
            if (edge_cnt == phase_start(p)) begin
              acc[p]    <= {7'd0, mic_data};
              primed[p] <= 1'b1;
            end else begin
              acc[p] <= sat_add(acc[p], mic_data);
            end
          end
        end
      end
    end
  end

  // Phase offsets are distinct, so at most one phase completes per strobe.
  always_comb begin
    push     = 1'b0;
    push_cnt = '0;
    if (enable && state == StRun && strobe) begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        if (edge_cnt == phase_last(p) && primed[p]) begin
          push     = 1'b1;
          push_cnt = encode(sat_add(acc[p], mic_data));
        end
      end
    end
  end

  // Output FIFO, first-word-fall-through.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_push;
  logic        drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_valid = !empty;
  assign s_data  = empty ? 8'd0 : mem[rd_ptr[AW-1:0]];
  assign pop     = s_valid && s_ready;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      // A drop in the same cycle as a clear wins.
      overflow <= drop || (overflow && !overflow_clr);
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Randomized scoreboard bench for pdm_capture_ctrl. The bench plays the microphone
// (new random bit after every mic_clk rise) and predicts each window sum directly
// from the recorded bit stream; a monitor pops predictions as the DUT emits samples.
module tb_pdm_capture_ctrl;

  localparam int unsigned CLK_DIV = 3;
  localparam int unsigned W       = 16;
  localparam int unsigned NPH     = 4;
  localparam int unsigned WARM    = 8;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned STRIDE  = W / NPH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       mic_clk;
  logic       mic_lr_sel;
  logic       mic_data = 1'b0;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready = 1'b0;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic       busy;

  pdm_capture_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .WIN_LEN      (W),
    .NUM_PHASES   (NPH),
    .WARMUP_EDGES (WARM),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mic_clk      (mic_clk),
    .mic_lr_sel   (mic_lr_sel),
    .mic_data     (mic_data),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pend_q[$];  // predictions issued by stimulus this cycle
  logic [7:0] exp_q[$];   // model FIFO contents
  logic       m_ovf = 1'b0;

  // Microphone / session model.
  bit   bits[$];
  int   rises = 0;
  int   cyc_since_rise = 0;
  bit   have_rise = 0;
  logic mic_prev = 1'b0;
  bit   en_want = 0;
  bit   push_now = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int cnt);
`ifdef PDM_CAPTURE_SIGNED_EN
    int v;
    v = cnt - int'(W / 2);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
`else
    return 8'(cnt);
`endif
  endfunction

  // ready_mode: 0 never, 1 always, 2 random, 3 only when a push is due.
  // clr_mode:   0 never, 1 this cycle, 2 only when a push is due.
  task automatic step(input int ready_mode, input int clr_mode);
    int r;
    int sum;
    bit b;
    @(negedge clk);
    enable = en_want;
    push_now = 0;
    cyc_since_rise++;
    if (!enable) begin
      rises = 0;
      have_rise = 0;
      bits.delete();
    end else if (mic_clk && !mic_prev) begin
      if (have_rise) chk("mic_clk_period", cyc_since_rise, 2 * CLK_DIV);
      have_rise = 1;
      cyc_since_rise = 0;
      rises++;
      b = 1'($urandom_range(0, 1));
      mic_data = b;
      if (rises > WARM) begin
        bits.push_back(b);
        r = bits.size() - 1;
        // A window ends every STRIDE run edges once a full WIN_LEN has been seen.
        if (r >= int'(W) - 1 && (r + 1) % STRIDE == 0) begin
          sum = 0;
          for (int i = r - int'(W) + 1; i <= r; i++) sum += int'(bits[i]);
          if (sum > 255) sum = 255;
          pend_q.push_back(enc(sum));
          push_now = 1;
        end
      end
    end
    mic_prev = mic_clk;
    case (ready_mode)
      0: s_ready = 1'b0;
      1: s_ready = 1'b1;
      2: s_ready = ($urandom_range(0, 3) != 0);
      default: s_ready = push_now;
    endcase
    case (clr_mode)
      0: overflow_clr = 1'b0;
      1: overflow_clr = 1'b1;
      default: overflow_clr = push_now;
    endcase
  endtask

  // Monitor: compares what the DUT presents, then applies this cycle's predicted push.
  initial begin
    logic [7:0] v;
    bit drop;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("s_valid", int'(s_valid), int'(exp_q.size() != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (s_valid && s_ready && exp_q.size() != 0) begin
          v = exp_q.pop_front();
          chk("s_data", int'(s_data), int'(v));
        end
        drop = 0;
        while (pend_q.size() != 0) begin
          v = pend_q.pop_front();
          if (exp_q.size() >= DEPTH) drop = 1;
          else exp_q.push_back(v);
        end
        m_ovf = drop || (m_ovf && !overflow_clr);
      end
    end
  end

  task automatic wait_fill(input int n);
    int k;
    k = 0;
    while (exp_q.size() < n && k < 2000) begin
      step(0, 0);
      k++;
    end
    if (k >= 2000) begin
      errors++;
      $display("FAIL fill_timeout got %0d expected %0d", exp_q.size(), n);
    end
  endtask

  initial begin
    int k;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mic_clk", int'(mic_clk), 0);
    chk("rst_lr_sel", int'(mic_lr_sel), 0);
    chk("rst_s_valid", int'(s_valid), 0);
    chk("rst_s_data", int'(s_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    #2 rst = 1'b0;

    // Random traffic.
    en_want = 1;
    repeat (600) step(2, 0);

    // Stall until samples are dropped, then clear on push cycles so the clear collides
    // with a drop, then a standalone clear.
    repeat (300) step(0, 0);
    repeat (100) step(0, 2);
    step(0, 1);
    // Full FIFO with push and pop together: no drop, occupancy holds.
    repeat (200) step(3, 0);
    // Drain and steady state.
    repeat (300) step(1, 0);
    repeat (200) step(2, 0);

    // Disable with three entries buffered.
    repeat (100) step(1, 0);
    wait_fill(3);
    en_want = 0;
    step(0, 0);
    step(0, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_mic_clk", int'(mic_clk), 0);
    repeat (60) step(1, 0);

    // Re-enable: warmup repeats.
    en_want = 1;
    repeat (400) step(2, 0);

    // Asynchronous reset mid-run with data buffered and overflow set.
    k = 0;
    while (!(m_ovf && mic_clk && exp_q.size() != 0) && k < 3000) begin
      step(0, 0);
      k++;
    end
    if (k >= 3000) begin
      errors++;
      $display("FAIL ovf_timeout got %0d expected 1", int'(m_ovf));
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_s_valid", int'(s_valid), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_mic_clk", int'(mic_clk), 0);
    chk("arst_busy", int'(busy), 0);
    exp_q.delete();
    pend_q.delete();
    m_ovf = 1'b0;
    en_want = 0;
    repeat (3) step(0, 0);
    #2 rst = 1'b0;

    en_want = 1;
    repeat (300) step(2, 0);
    en_want = 0;
    repeat (100) step(1, 0);
    chk("final_model_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
